// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the pipeline valid/ready controller:
//   - state_t : controller FSM state encoding (EMPTY/FILL/FULL/FLUSH)
//   - DEFAULT_STAGES : default number of controlled latch stages
package pipeline_pkg;

    localparam int DEFAULT_STAGES = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/pipeline_stage_ctrl.sv
// pipeline_stage_ctrl
// Control slice for one pipeline latch: holds the stage valid bit, computes
// the stage ready term of the backpressure chain and the latch load enable.
// Ports:
//   clk        in  clock
//   RST        in  synchronous active-low reset
//   up_valid   in  valid of the producer feeding this stage
//   dn_ready   in  ready of the consumer after this stage
//   hold       in  blocks loading (flush request or FLUSH state)
//   clear      in  forces the next valid bit to zero (flush)
//   valid      out registered valid bit
//   ready      out stage can take a word this cycle
//   en         out latch load enable
//   valid_next out next-state valid bit (feeds the occupancy count)
module pipeline_stage_ctrl (
    input  logic clk,
    input  logic RST,
    input  logic up_valid,
    input  logic dn_ready,
    input  logic hold,
    input  logic clear,
    output logic valid,
    output logic ready,
    output logic en,
    output logic valid_next
);

    // A stage is ready when it is empty or its contents move on this cycle.
    assign ready      = ~valid | dn_ready;
    assign en         = up_valid & ready & ~hold;
    assign valid_next = clear ? 1'b0 : (en | (valid & ~dn_ready));

    always_ff @(posedge clk) begin
        if (!RST) begin
            valid <= 1'b0;
        end else begin
            valid <= valid_next;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Valid/ready controller for a chain of STAGES pipeline latches. Generates
// per-stage load enables, tracks occupancy, propagates backpressure
// combinationally from the consumer to the producer and supports a
// synchronous flush. It never touches data.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready of the same interface, while the
// ready chain (in_ready) depends combinationally on out_ready.
//
// Ports:
//   clk          in  clock
//   RST          in  synchronous active-low reset
//   in_valid     in  producer has a word for stage 0
//   in_ready     out stage 0 accepts this cycle
//   out_ready    in  consumer accepts from the last stage
//   out_valid    out last stage holds valid data
//   flush        in  discard all in-flight data
//   stage_en     out load enable per latch
//   stage_valid  out registered valid bit per stage
//   occupancy    out registered count of valid stages
//   state        out FSM state (EMPTY/FILL/FULL/FLUSH)
//   stall_cnt    out saturating count of out_valid & ~out_ready cycles
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int STAGES  = DEFAULT_STAGES,
    parameter int CNT_W   = $clog2(STAGES + 1),
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               out_ready,
    output logic               out_valid,
    input  logic               flush,
    output logic [STAGES-1:0]  stage_en,
    output logic [STAGES-1:0]  stage_valid,
    output logic [CNT_W-1:0]   occupancy,
    output logic [1:0]         state,
    output logic [STALL_W-1:0] stall_cnt
);

    state_t              state_q;
    state_t              state_d;
    logic [STAGES-1:0]   v;
    logic [STAGES-1:0]   v_next;
    logic [STAGES-1:0]   r;
    logic [STAGES-1:0]   en;
    logic [CNT_W-1:0]    occ_next;
    logic [CNT_W-1:0]    occ_q;
    logic [STALL_W-1:0]  stall_q;
    logic                block;

    // Loading is blocked both on the flush request cycle and the FLUSH cycle.
    assign block = flush | (state_q == FLUSH);

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic up_v;
        logic dn_r;

        if (i == 0) begin : g_first
            assign up_v = in_valid;
        end else begin : g_inner_up
            assign up_v = v[i-1];
        end

        if (i == STAGES - 1) begin : g_last
            assign dn_r = out_ready;
        end else begin : g_inner_dn
            assign dn_r = r[i+1];
        end

        pipeline_stage_ctrl u_stage (
            .clk        (clk),
            .RST        (RST),
            .up_valid   (up_v),
            .dn_ready   (dn_r),
            .hold       (block),
            .clear      (flush),
            .valid      (v[i]),
            .ready      (r[i]),
            .en         (en[i]),
            .valid_next (v_next[i])
        );
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_next = occ_next + CNT_W'(v_next[i]);
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. FLUSH always lasts exactly one cycle, even if flush
    // stays high; a held flush re-enters FLUSH from EMPTY the cycle after.
    always_comb begin
        state_d = state_q;
        if (state_q == FLUSH) begin
            state_d = EMPTY;
        end else if (flush) begin
            state_d = FLUSH;
        end else if (occ_next == '0) begin
            state_d = EMPTY;
        end else if (occ_next == CNT_W'(STAGES)) begin
            state_d = FULL;
        end else begin
            state_d = FILL;
        end
    end

    // FSM: outputs. While in reset the producer sees a ready stage 0.
    always_comb begin
        in_ready    = ~RST | (r[0] & ~block);
        stage_en    = en;
        stage_en[0] = in_valid & in_ready;
        out_valid   = v[STAGES-1];
        stage_valid = v;
        state       = state_q;
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_next;
        end
    end

    assign occupancy = occ_q;

    // Flush does not clear the stall counter; only reset does.
    always_ff @(posedge clk) begin
        if (!RST) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
    import pipeline_pkg::*;

    localparam int S = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic        flush;
    logic [S-1:0] stage_en;
    logic [S-1:0] stage_valid;
    logic [2:0]  occupancy;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int total;
    int bad;

    pipeline_ctrl #(.STAGES(S), .CNT_W(3), .STALL_W(16)) dut (
        .clk         (clk),
        .RST         (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .flush       (flush),
        .stage_en    (stage_en),
        .stage_valid (stage_valid),
        .occupancy   (occupancy),
        .state       (state),
        .stall_cnt   (stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // directed vectors: inputs for one cycle, combinational outputs during
    // that cycle and registered outputs after its edge
    typedef struct {
        logic        iv;
        logic        orr;
        logic        fl;
        logic        ir;
        logic [3:0]  en;
        logic        ov;
        logic [3:0]  sv;
        logic [2:0]  occ;
        logic [1:0]  st;
        logic [15:0] stall;
    } vec_t;

    function automatic vec_t mk(logic iv, logic orr, logic fl, logic ir, logic [3:0] en,
                                logic ov, logic [3:0] sv, logic [2:0] occ, logic [1:0] st,
                                logic [15:0] stall);
        vec_t t;
        t.iv = iv; t.orr = orr; t.fl = fl; t.ir = ir; t.en = en; t.ov = ov;
        t.sv = sv; t.occ = occ; t.st = st; t.stall = stall;
        return t;
    endfunction

    // reference model: slots advance whenever any slot further downstream is
    // empty or the consumer takes the last word
    logic [S-1:0] m_v;
    logic [1:0]   m_state;
    int           m_stall;

    function automatic logic hole_from(logic [S-1:0] vv, logic orr, int i);
        logic f;
        f = orr;
        for (int j = i; j < S; j++) if (!vv[j]) f = 1'b1;
        return f;
    endfunction

    function automatic int popcount(logic [S-1:0] vv);
        int n;
        n = 0;
        for (int j = 0; j < S; j++) n += int'(vv[j]);
        return n;
    endfunction

    task automatic model_comb(output logic ir, output logic [S-1:0] en);
        logic blocked;
        blocked = flush || (m_state == 2'd3);
        ir = !blocked && hole_from(m_v, out_ready, 0);
        if (!rst_n) ir = 1'b1;
        en = '0;
        en[0] = in_valid && ir;
        for (int i = 1; i < S; i++) en[i] = !blocked && m_v[i-1] && hole_from(m_v, out_ready, i);
    endtask

    task automatic model_step(input logic [S-1:0] en);
        logic [S-1:0] nv;
        int cnt;
        if (!rst_n) begin
            m_v = '0; m_state = 2'd0; m_stall = 0;
        end else begin
            if (m_v[S-1] && !out_ready && m_stall < 65535) m_stall++;
            for (int i = 0; i < S; i++)
                nv[i] = en[i] || (m_v[i] && !hole_from(m_v, out_ready, i + 1));
            if (flush) nv = '0;
            cnt = popcount(nv);
            if (m_state == 2'd3) m_state = 2'd0;
            else if (flush) m_state = 2'd3;
            else if (cnt == 0) m_state = 2'd0;
            else if (cnt == S) m_state = 2'd2;
            else m_state = 2'd1;
            m_v = nv;
        end
    endtask

    vec_t tbl[24];
    logic         e_ir;
    logic [S-1:0] e_en;

    initial begin
        total = 0;
        bad = 0;
        tbl[0]  = mk(1,1,0, 1,4'b0001,0, 4'b0001,1,2'd1,0);
        tbl[1]  = mk(0,1,0, 1,4'b0010,0, 4'b0010,1,2'd1,0);
        tbl[2]  = mk(0,1,0, 1,4'b0100,0, 4'b0100,1,2'd1,0);
        tbl[3]  = mk(0,1,0, 1,4'b1000,0, 4'b1000,1,2'd1,0);
        tbl[4]  = mk(0,1,0, 1,4'b0000,1, 4'b0000,0,2'd0,0);
        tbl[5]  = mk(1,0,0, 1,4'b0001,0, 4'b0001,1,2'd1,0);
        tbl[6]  = mk(1,0,0, 1,4'b0011,0, 4'b0011,2,2'd1,0);
        tbl[7]  = mk(1,0,0, 1,4'b0111,0, 4'b0111,3,2'd1,0);
        tbl[8]  = mk(1,0,0, 1,4'b1111,0, 4'b1111,4,2'd2,0);
        tbl[9]  = mk(1,0,0, 0,4'b0000,1, 4'b1111,4,2'd2,1);
        tbl[10] = mk(1,0,0, 0,4'b0000,1, 4'b1111,4,2'd2,2);
        tbl[11] = mk(1,0,0, 0,4'b0000,1, 4'b1111,4,2'd2,3);
        tbl[12] = mk(1,1,0, 1,4'b1111,1, 4'b1111,4,2'd2,3);
        tbl[13] = mk(1,1,0, 1,4'b1111,1, 4'b1111,4,2'd2,3);
        tbl[14] = mk(1,1,0, 1,4'b1111,1, 4'b1111,4,2'd2,3);
        tbl[15] = mk(0,1,0, 1,4'b1110,1, 4'b1110,3,2'd1,3);
        tbl[16] = mk(1,1,1, 0,4'b0000,1, 4'b0000,0,2'd3,3);
        tbl[17] = mk(1,1,0, 0,4'b0000,0, 4'b0000,0,2'd0,3);
        tbl[18] = mk(0,1,0, 1,4'b0000,0, 4'b0000,0,2'd0,3);
        tbl[19] = mk(1,1,1, 0,4'b0000,0, 4'b0000,0,2'd3,3);
        tbl[20] = mk(1,1,1, 0,4'b0000,0, 4'b0000,0,2'd0,3);
        tbl[21] = mk(1,1,1, 0,4'b0000,0, 4'b0000,0,2'd3,3);
        tbl[22] = mk(0,1,0, 0,4'b0000,0, 4'b0000,0,2'd0,3);
        tbl[23] = mk(0,1,0, 1,4'b0000,0, 4'b0000,0,2'd0,3);

        // reset with random inputs
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = 1'($urandom_range(0, 1));
            #2;
            check("rst_in_ready", in_ready, 1);
            check("rst_stage_en0", stage_en[0], in_valid);
            @(posedge clk); #1;
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        check("reset_occupancy", occupancy, 0);
        check("reset_state", state, 0);
        check("reset_stall", stall_cnt, 0);
        check("reset_stage_valid", stage_valid, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);

        // directed table
        for (int k = 0; k < 24; k++) begin
            in_valid = tbl[k].iv; out_ready = tbl[k].orr; flush = tbl[k].fl;
            #2;
            check($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].ir);
            check($sformatf("tbl%0d_stage_en", k), stage_en, tbl[k].en);
            check($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].ov);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_stage_valid", k), stage_valid, tbl[k].sv);
            check($sformatf("tbl%0d_occupancy", k), occupancy, tbl[k].occ);
            check($sformatf("tbl%0d_state", k), state, tbl[k].st);
            check($sformatf("tbl%0d_stall", k), stall_cnt, tbl[k].stall);
        end

        // reset wins over flush: fill under stall until stall_cnt reaches 5
        in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("pre_rst_stall", stall_cnt, 5);
        check("pre_rst_state", state, 2);
        rst_n = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        check("rst_flush_state", state, 0);
        check("rst_flush_stall", stall_cnt, 0);
        check("rst_flush_occ", occupancy, 0);
        check("rst_flush_sv", stage_valid, 0);
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        m_v = '0; m_state = 2'd0; m_stall = 0;

        // randomized run against the reference model
        for (int k = 0; k < 3000; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            #2;
            model_comb(e_ir, e_en);
            check("rnd_in_ready", in_ready, e_ir);
            if (rst_n) check("rnd_stage_en", stage_en, e_en);
            else check("rnd_stage_en0", stage_en[0], e_en[0]);
            check("rnd_out_valid", out_valid, m_v[S-1]);
            @(posedge clk); #1;
            model_step(e_en);
            check("rnd_stage_valid", stage_valid, m_v);
            check("rnd_occupancy", occupancy, popcount(m_v));
            check("rnd_state", state, m_state);
            check("rnd_stall", stall_cnt, m_stall);
        end

        // stall counter saturation
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4 + 65534) begin
            @(posedge clk); #1;
        end
        check("sat_minus1", stall_cnt, 16'hFFFE);
        @(posedge clk); #1;
        check("sat_reach", stall_cnt, 16'hFFFF);
        @(posedge clk); #1;
        check("sat_hold", stall_cnt, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
